// File: rtl/tl_ul_pkg.sv
// TL-UL opcodes, field widths and response queue depth shared by the SRAM slave.
// Declarations only: no logic, no latency, no flow control.
package tl_ul_pkg;

  localparam int TL_AW      = 32;
  localparam int TL_DW      = 32;
  localparam int TL_MW      = 4;
  localparam int TL_OPW     = 3;
  localparam int TL_SZW     = 2;
  localparam int TL_DPW     = 2;
  localparam int RESP_DEPTH = 3;

  typedef enum logic [TL_OPW-1:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [TL_OPW-1:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

endpackage

// File: rtl/tl_resp_fifo.sv
// Small register-array FIFO with mod-DEPTH pointers; push to pop_data visible next cycle.
// Simultaneous push/pop keeps count; push is dropped only if full without a pop.
module tl_resp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 32,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload needs no reset: it is only observed while count says it is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= push_data;
  end

  assign pop_data = mem[rptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/tl_ul_sram_slave.sv
// TL-UL to single-port SRAM bridge; accept-to-d_valid latency 2 cycles, one beat/cycle sustained.
// a_ready drops once s1 plus the 3-entry response queue hold 3 requests; d_ready stalls hold D stable.
module tl_ul_sram_slave
  import tl_ul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          SOURCE_W    = 2,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [TL_OPW-1:0]   a_opcode,
  input  logic [2:0]          a_param,
  input  logic [TL_SZW-1:0]   a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [TL_AW-1:0]    a_address,
  input  logic [TL_MW-1:0]    a_mask,
  input  logic [TL_DW-1:0]    a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [TL_OPW-1:0]   d_opcode,
  output logic [TL_DPW-1:0]   d_param,
  output logic [TL_SZW-1:0]   d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [TL_DW-1:0]    d_data,
  output logic                sram_en,
  output logic                sram_we,
  output logic [AW-1:0]       sram_addr,
  output logic [TL_MW-1:0]    sram_wmask,
  output logic [TL_DW-1:0]    sram_wdata,
  input  logic [TL_DW-1:0]    sram_rdata
);

  typedef struct packed {
    logic [TL_OPW-1:0]   opcode;
    logic [TL_SZW-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic                corrupt;
    logic [TL_DW-1:0]    data;
  } rsp_t;

  localparam int          CW    = $clog2(RESP_DEPTH + 1);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  logic                s1_valid;
  logic                s1_get;
  logic                s1_err;
  logic [TL_SZW-1:0]   s1_size;
  logic [SOURCE_W-1:0] s1_source;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  rsp_t                push_rsp;
  rsp_t                head;
  logic                accept;
  logic                op_ok;
  logic                align_ok;
  logic                addr_ok;
  logic                a_err;
  logic [31:0]         offset;
  logic                unused_bits;

  // Only registers and reset feed a_ready, so D-side backpressure never reaches A combinationally.
  assign a_ready = reset_n && ((3'(fifo_count) + 3'(s1_valid)) < 3'(RESP_DEPTH));
  assign accept  = a_valid && a_ready;

  assign op_ok = (a_opcode == PUT_FULL_DATA) || (a_opcode == PUT_PARTIAL_DATA) || (a_opcode == GET);

  always_comb begin
    align_ok = 1'b0;
    case (a_size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = !a_address[0];
      2'd2:    align_ok = (a_address[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign addr_ok = ({1'b0, a_address} >= {1'b0, BASE_ADDR}) && ({1'b0, a_address} < LIMIT);
  assign a_err   = !(op_ok && align_ok && addr_ok);
  assign offset  = a_address - BASE_ADDR;

  assign sram_en    = accept && !a_err;
  assign sram_we    = sram_en && (a_opcode != GET);
  assign sram_addr  = offset[AW+1:2];
  assign sram_wmask = sram_we ? a_mask : '0;
  assign sram_wdata = a_data;

  assign unused_bits = ^{a_param, offset[31:AW+2], offset[1:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_get    <= 1'b0;
      s1_err    <= 1'b0;
      s1_size   <= '0;
      s1_source <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_get    <= (a_opcode == GET);
        s1_err    <= a_err;
        s1_size   <= a_size;
        s1_source <= a_source;
      end
    end
  end

  // Read data arrives the cycle after the strobe, exactly when s1 pushes.
  always_comb begin
    push_rsp.opcode  = s1_get ? ACCESS_ACK_DATA : ACCESS_ACK;
    push_rsp.size    = s1_size;
    push_rsp.source  = s1_source;
    push_rsp.denied  = s1_err;
    push_rsp.corrupt = s1_err && s1_get;
    push_rsp.data    = (s1_get && !s1_err) ? sram_rdata : '0;
  end

  tl_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (s1_valid),
    .push_data (push_rsp),
    .pop       (d_valid && d_ready),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign d_valid   = !fifo_empty;
  assign d_opcode  = head.opcode;
  assign d_param   = '0;
  assign d_size    = head.size;
  assign d_source  = head.source;
  assign d_denied  = head.denied;
  assign d_corrupt = head.corrupt;
  assign d_data    = head.data;

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Directed bench for tl_ul_sram_slave with a behavioural SRAM and negedge monitors.
// Expected values are hand-computed constants per vector.
module tb_tl_ul_sram_slave;

  localparam logic [2:0] OP_PF = 3'd0;
  localparam logic [2:0] OP_PP = 3'd1;
  localparam logic [2:0] OP_GET = 3'd4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [1:0]  d_size;
  logic [1:0]  d_source;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;
  logic        sram_en;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [3:0]  sram_wmask;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  tl_ul_sram_slave dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_data(d_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wmask(sram_wmask),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [1024];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic        den;
    logic        cor;
    logic [1:0]  src;
    logic [1:0]  sz;
    logic [31:0] dat;
    int          cyc;
  } rsp_s;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  wm;
    logic [31:0] wd;
  } acc_s;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdy_low = 0;
  int   acc_q[$];
  rsp_s rsp_q[$];
  acc_s sram_q[$];
  rsp_s r_tmp;
  acc_s s_tmp;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n) begin
      if (a_valid && a_ready) acc_q.push_back(cyc);
      if (a_valid && !a_ready) rdy_low++;
      if (d_valid && d_ready) begin
        r_tmp.op  = d_opcode;
        r_tmp.den = d_denied;
        r_tmp.cor = d_corrupt;
        r_tmp.src = d_source;
        r_tmp.sz  = d_size;
        r_tmp.dat = d_data;
        r_tmp.cyc = cyc;
        rsp_q.push_back(r_tmp);
      end
      if (sram_en) begin
        s_tmp.we   = sram_we;
        s_tmp.addr = sram_addr;
        s_tmp.wm   = sram_wmask;
        s_tmp.wd   = sram_wdata;
        sram_q.push_back(s_tmp);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    acc_q.delete();
    rsp_q.delete();
    sram_q.delete();
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [1:0] src,
                      input logic [31:0] addr, input logic [3:0] msk, input logic [31:0] dat);
    int t;
    t = 0;
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = msk; a_data = dat;
    @(negedge clock);
    while (!a_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!a_ready) chk("a_ready_timeout", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    a_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    while (rsp_q.size() < n && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    chk("rsp_count", 32'(rsp_q.size()), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int bad;
    reset_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
    a_source = '0; a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b0;
    #2;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rdy_after_rst", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    d_ready = 1'b1;

    // PutFull then Get of the same word
    clear_q();
    send(OP_PF, 2'd2, 2'd0, 32'h8000_0004, 4'hF, 32'hDEAD_BEEF);
    send(OP_GET, 2'd2, 2'd1, 32'h8000_0004, 4'hF, 32'h0);
    wait_rsp(2);
    chk("put_op_den", {27'd0, rsp_q[0].op, rsp_q[0].den, rsp_q[0].cor}, {27'd0, 3'd0, 1'b0, 1'b0});
    chk("put_latency", 32'(rsp_q[0].cyc - acc_q[0]), 32'd2);
    chk("get_op_den", {27'd0, rsp_q[1].op, rsp_q[1].den, rsp_q[1].cor}, {27'd0, 3'd1, 1'b0, 1'b0});
    chk("get_data", rsp_q[1].dat, 32'hDEAD_BEEF);
    chk("get_src_sz", {28'd0, rsp_q[1].src, rsp_q[1].sz}, {28'd0, 2'd1, 2'd2});
    chk("get_latency", 32'(rsp_q[1].cyc - acc_q[1]), 32'd2);
    chk("d_param", 32'(d_param), 32'd0);

    // PutPartial over an old word
    clear_q();
    send(OP_PF, 2'd2, 2'd0, 32'h8000_0008, 4'hF, 32'hAAAA_AAAA);
    send(OP_PP, 2'd2, 2'd1, 32'h8000_0008, 4'h3, 32'h1234_5678);
    send(OP_GET, 2'd2, 2'd2, 32'h8000_0008, 4'hF, 32'h0);
    wait_rsp(3);
    chk("pp_data", rsp_q[2].dat, 32'hAAAA_5678);
    chk("pp_ack_op", 32'(rsp_q[1].op), 32'd0);
    chk("pp_sram", {17'd0, sram_q[1].we, sram_q[1].addr, sram_q[1].wm}, {17'd0, 1'b1, 10'd2, 4'h3});
    chk("pp_wdata", sram_q[1].wd, 32'h1234_5678);
    chk("get_sram", {17'd0, sram_q[2].we, sram_q[2].addr, sram_q[2].wm}, {17'd0, 1'b0, 10'd2, 4'h0});

    // Erroneous requests never reach the SRAM
    clear_q();
    send(OP_GET, 2'd2, 2'd0, 32'h7FFF_FFFC, 4'hF, 32'h0);
    send(OP_GET, 2'd2, 2'd1, 32'h8000_1000, 4'hF, 32'h0);
    send(3'd2, 2'd2, 2'd2, 32'h8000_0000, 4'hF, 32'h5555_5555);
    send(OP_GET, 2'd2, 2'd3, 32'h8000_0002, 4'hF, 32'h0);
    wait_rsp(4);
    chk("err_no_sram", 32'(sram_q.size()), 32'd0);
    chk("err_below", {27'd0, rsp_q[0].op, rsp_q[0].den, rsp_q[0].cor}, {27'd0, 3'd1, 1'b1, 1'b1});
    chk("err_above", {27'd0, rsp_q[1].op, rsp_q[1].den, rsp_q[1].cor}, {27'd0, 3'd1, 1'b1, 1'b1});
    chk("err_opcode", {27'd0, rsp_q[2].op, rsp_q[2].den, rsp_q[2].cor}, {27'd0, 3'd0, 1'b1, 1'b0});
    chk("err_align", {27'd0, rsp_q[3].op, rsp_q[3].den, rsp_q[3].cor}, {27'd0, 3'd1, 1'b1, 1'b1});
    chk("err_data", rsp_q[0].dat, 32'h0);

    // Last legal word
    clear_q();
    send(OP_PF, 2'd2, 2'd0, 32'h8000_0FFC, 4'hF, 32'h0BAD_F00D);
    send(OP_GET, 2'd2, 2'd1, 32'h8000_0FFC, 4'hF, 32'h0);
    wait_rsp(2);
    chk("top_addr", 32'(sram_q[0].addr), 32'd1023);
    chk("top_get", {rsp_q[1].den, rsp_q[1].dat[30:0]}, {1'b0, 31'h0BAD_F00D});

    // Backpressure: d_ready low, continuous a_valid
    clear_q();
    d_ready = 1'b0;
    a_opcode = OP_GET; a_size = 2'd2; a_address = 32'h8000_0004; a_mask = 4'hF;
    a_valid = 1'b1;
    repeat (10) begin
      a_source = 2'(acc_q.size());
      @(posedge clock); #1;
    end
    chk("bp_accepts", 32'(acc_q.size()), 32'd3);
    chk("bp_a_ready", 32'(a_ready), 32'd0);
    chk("bp_head", {d_valid, d_source, d_data[28:0]}, {1'b1, 2'd0, 29'h1EAD_BEEF});
    d_ready = 1'b1;
    repeat (6) begin
      a_source = 2'(acc_q.size());
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
    wait_rsp(acc_q.size());
    chk("bp_order", {26'd0, rsp_q[0].src, rsp_q[1].src, rsp_q[2].src}, {26'd0, 2'd0, 2'd1, 2'd2});
    chk("bp_resumed", 32'(acc_q.size() > 3), 32'd1);

    // Sustained one request per cycle
    clear_q();
    rdy_low = 0;
    a_valid = 1'b1;
    repeat (100) begin
      a_source = 2'(acc_q.size());
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
    wait_rsp(100);
    chk("b2b_accepts", 32'(acc_q.size()), 32'd100);
    chk("b2b_rdy_low", 32'(rdy_low), 32'd0);
    bad = 0;
    for (int i = 0; i < rsp_q.size(); i++)
      if (rsp_q[i].src != 2'(i) || rsp_q[i].dat != 32'hDEAD_BEEF) bad++;
    chk("b2b_order", 32'(bad), 32'd0);

    // Reset with queued responses
    clear_q();
    d_ready = 1'b0;
    send(OP_GET, 2'd2, 2'd1, 32'h8000_0004, 4'hF, 32'h0);
    send(OP_GET, 2'd2, 2'd2, 32'h8000_0004, 4'hF, 32'h0);
    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("pre_rst_dvalid", 32'(d_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_dvalid", 32'(d_valid), 32'd0);
    chk("mid_rst_aready", 32'(a_ready), 32'd0);
    #1 reset_n = 1'b1;
    clear_q();
    d_ready = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
    end
    chk("no_stale", 32'(rsp_q.size()), 32'd0);
    send(OP_GET, 2'd2, 2'd3, 32'h8000_0004, 4'hF, 32'h0);
    wait_rsp(1);
    chk("post_rst_get", {rsp_q[0].src, rsp_q[0].dat[29:0]}, {2'd3, 30'h1EAD_BEEF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_ul_sram_slave.md
TL_UL_SRAM_SLAVE -- requirements
Module: tl_ul_sram_slave

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, 32'h8000_0000, first byte address served; DEPTH_WORDS, 1024, SRAM depth in 32-bit words (power of 2); SOURCE_W, 2, TL source width; AW, log2(DEPTH_WORDS), SRAM address width.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
clock  in  1  sole clock, rising edge.
reset_n  in  1  async active-low reset.
a_valid/a_ready  in/out  1/1  TL-UL A handshake from the AHB-to-TL port.
a_opcode  in  3  0 PutFullData, 1 PutPartialData, 4 Get.
a_param  in  3  ignored.
a_size  in  2  log2 bytes.
a_source  in  SOURCE_W  request ID.
a_address  in  32  byte address.
a_mask  in  4  byte lanes.
a_data  in  32  write data.
d_valid/d_ready  out/in  1/1  TL-UL D handshake.
d_opcode  out  3  0 AccessAck, 1 AccessAckData.
d_param  out  2  always 0.
d_size  out  2  echoed a_size.
d_source  out  SOURCE_W  echoed a_source.
d_denied  out  1  request rejected.
d_corrupt  out  1  read data invalid.
d_data  out  32  read data.
sram_en  out  1  SRAM access strobe.
sram_we  out  1  write when high.
sram_addr  out  AW  word address.
sram_wmask  out  4  byte write enables.
sram_wdata  out  32  write data.
sram_rdata  in  32  valid the cycle after sram_en with sram_we=0.

Function
REQ-004 An A beat SHALL be accepted when a_valid && a_ready; a_ready SHALL be (queue_count + s1_valid) < 3, with no combinational path from d_ready or a_valid to a_ready.
REQ-005 A request SHALL be erroneous if: opcode not in {0,1,4}; a_size > 2; address not aligned to 2^a_size; or address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
REQ-006 In the accept cycle of a legal request, sram_en SHALL be 1, sram_addr = (a_address - BASE_ADDR)[AW+1:2], sram_we = (opcode != Get), sram_wmask = a_mask for puts and 0 for Get, sram_wdata = a_data; otherwise sram_en = 0 and sram_we = 0.
REQ-007 Erroneous requests SHALL NOT touch the SRAM.
REQ-008 Each accepted request SHALL load stage s1 (opcode, size, source, error); the next cycle s1 SHALL push one entry into a 3-entry response FIFO, capturing sram_rdata for legal Gets and 0 otherwise.
REQ-009 Responses SHALL be: d_opcode = 1 for Get and 0 for puts (including erroneous requests); d_denied = error; d_corrupt = error && Get; d_size and d_source echoed.
REQ-010 d_valid SHALL equal FIFO not empty, driven from registers; minimum accept-to-d_valid latency SHALL be 2 cycles.
REQ-011 Responses SHALL be returned in acceptance order.
REQ-012 With d_ready held high, one request per cycle SHALL be sustained indefinitely.
REQ-013 D outputs SHALL stay stable while d_valid && !d_ready.
REQ-014 In a cycle with both a FIFO push and a pop, count SHALL be unchanged and the data SHALL be correct, including at count = 3 and count = 0.
REQ-015 FIFO pointers SHALL wrap modulo 3.
REQ-016 By construction of REQ-004, the FIFO SHALL never overflow.

Reset
REQ-017 Asserting reset_n low SHALL clear s1_valid, the FIFO count, and the pointers immediately, discarding in-flight requests.
REQ-018 During reset, a_ready, d_valid, sram_en and sram_we SHALL be 0.
REQ-019 After release, a_ready SHALL be 1 in the first clock cycle.
REQ-020 FIFO data storage SHALL NOT require reset.

Structure
REQ-021 A shared package tl_ul_pkg SHALL hold the TL opcode constants, the D opcode constants, and the A/D field widths.
REQ-022 The response FIFO SHALL be a sub-module tl_resp_fifo with parameters DEPTH = 3 and WIDTH.

Verification
REQ-023 Get 0x8000_0004 after PutFull 0x8000_0004 with data 0xDEAD_BEEF, mask 0xF -> AccessAck, then AccessAckData with 0xDEAD_BEEF, d_valid 2 cycles after each accept.
REQ-024 PutPartial with mask 0x3 and data 0x1234_5678 over an old word 0xAAAA_AAAA -> a following Get returns 0xAAAA_5678.
REQ-025 Get 0x7FFF_FFFC, Get 0x8000_1000, opcode 2, and Get with size 2 at 0x8000_0002 -> sram_en never asserted; d_denied = 1 and d_corrupt = 1 for the Gets; opcode 2 -> AccessAck, d_denied = 1, d_corrupt = 0.
REQ-026 d_ready held low with a continuous a_valid -> exactly 3 accepts, then a_ready = 0; releasing d_ready -> 3 responses in order with sources 0, 1, 2, and acceptance resumes.
REQ-027 Back-to-back Gets with d_ready = 1 over 100 cycles -> 100 responses, a_ready never 0 after the first cycle.
REQ-028 reset_n pulsed low with 2 responses queued -> d_valid = 0 immediately; no stale responses after release.
